// File: rtl/fabric_config_loader.sv
// Framed configuration loader: decodes header words and writes payload words into the
// routing-block and IO-block select registers, gating fabric_en until a clean commit.
module fabric_config_loader #(
  parameter int unsigned WORD     = 30,
  parameter int unsigned BRB_BITS = 900,
  parameter int unsigned IO_BITS  = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORD-1:0]     cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [BRB_BITS-1:0] brbselect,
  output logic [IO_BITS-1:0]  leftioselect,
  output logic [IO_BITS-1:0]  rightioselect,
  output logic [IO_BITS-1:0]  topioselect,
  output logic [IO_BITS-1:0]  bottomioselect,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic                cfg_error,
  output logic                fabric_en
);

  localparam int unsigned BRB_WORDS = BRB_BITS / WORD;

  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  localparam logic [2:0] TgtBrb    = 3'd0;
  localparam logic [2:0] TgtLeft   = 3'd1;
  localparam logic [2:0] TgtRight  = 3'd2;
  localparam logic [2:0] TgtTop    = 3'd3;
  localparam logic [2:0] TgtBottom = 3'd4;
  localparam logic [2:0] TgtBad    = 3'd5;
  localparam logic [2:0] TgtClear  = 3'd6;

  state_e              state_q;
  logic                ready_q;
  logic [2:0]          tgt_q;
  logic [5:0]          ptr_q;
  logic [5:0]          remain_q;
  logic [BRB_BITS-1:0] brb_q;
  logic [IO_BITS-1:0]  left_q, right_q, top_q, bottom_q;
  logic                done_q, error_q, en_q;

  // Header field decode
  logic [7:0] hdr_magic;
  logic [5:0] hdr_start;
  logic [4:0] hdr_cnt_m1;
  logic [2:0] hdr_target;
  logic [6:0] hdr_n;
  logic [6:0] hdr_end;
  logic       range_bad;
  logic       hdr_bad;
  logic       xfer;

  always_comb begin
    hdr_magic  = cfg_data[29:22];
    hdr_start  = cfg_data[13:8];
    hdr_cnt_m1 = cfg_data[7:3];
    hdr_target = cfg_data[2:0];
    hdr_n      = {2'b00, hdr_cnt_m1} + 7'd1;
    hdr_end    = {1'b0, hdr_start} + hdr_n;
    if (hdr_target == TgtBrb) begin
      range_bad = (hdr_end > 7'(BRB_WORDS));
    end else begin
      range_bad = (hdr_start != 6'd0) || (hdr_cnt_m1 != 5'd0);
    end
    hdr_bad = (hdr_magic != 8'hA5) || (hdr_target == TgtBad) ||
              ((hdr_target <= TgtBottom) && range_bad);
    xfer    = cfg_valid && ready_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ready_q  <= 1'b0;
      tgt_q    <= TgtBrb;
      ptr_q    <= '0;
      remain_q <= '0;
      brb_q    <= '0;
      left_q   <= '0;
      right_q  <= '0;
      top_q    <= '0;
      bottom_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      // Ready comes up one cycle after reset release.
      ready_q <= 1'b1;
      if (xfer) begin
        unique case (state_q)
          StIdle: begin
            if (hdr_bad) begin
              error_q <= 1'b1;
            end else if (hdr_target <= TgtBottom) begin
              tgt_q    <= hdr_target;
              ptr_q    <= hdr_start;
              remain_q <= hdr_n[5:0];
              en_q     <= 1'b0;
              done_q   <= 1'b0;
              state_q  <= StLoad;
            end else if (hdr_target == TgtClear) begin
              brb_q    <= '0;
              left_q   <= '0;
              right_q  <= '0;
              top_q    <= '0;
              bottom_q <= '0;
              done_q   <= 1'b0;
              en_q     <= 1'b0;
              error_q  <= 1'b0;
            end else if (!error_q) begin
              done_q <= 1'b1;
              en_q   <= 1'b1;
            end
          end
          StLoad: begin
            case (tgt_q)
              TgtBrb:    brb_q[ptr_q*WORD +: WORD] <= cfg_data;
              TgtLeft:   left_q   <= cfg_data;
              TgtRight:  right_q  <= cfg_data;
              TgtTop:    top_q    <= cfg_data;
              default:   bottom_q <= cfg_data;
            endcase
            ptr_q    <= ptr_q + 6'd1;
            remain_q <= remain_q - 6'd1;
            if (remain_q == 6'd1) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign cfg_ready      = ready_q;
  assign cfg_busy       = (state_q == StLoad);
  assign cfg_done       = done_q;
  assign cfg_error      = error_q;
  assign fabric_en      = en_q;
  assign brbselect      = brb_q;
  assign leftioselect   = left_q;
  assign rightioselect  = right_q;
  assign topioselect    = top_q;
  assign bottomioselect = bottom_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader with hand-computed expectations.
module tb_fabric_config_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [29:0]  cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [899:0] brbselect;
  logic [29:0]  leftioselect, rightioselect, topioselect, bottomioselect;
  logic         cfg_busy, cfg_done, cfg_error, fabric_en;

  int tests = 0;
  int fails = 0;

  logic [899:0] exp_brb;

  fabric_config_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_data       (cfg_data),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .brbselect      (brbselect),
    .leftioselect   (leftioselect),
    .rightioselect  (rightioselect),
    .topioselect    (topioselect),
    .bottomioselect (bottomioselect),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .cfg_error      (cfg_error),
    .fabric_en      (fabric_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Flags packed as {ready, busy, done, error, fabric_en}
  task automatic check_flags(input string tag, input logic [4:0] exp);
    check({tag, " flags"}, {25'd0, cfg_ready, cfg_busy, cfg_done, cfg_error, fabric_en},
          {25'd0, exp});
  endtask

  task automatic check_sel(input string tag, input logic [899:0] eb, input logic [29:0] l,
                           input logic [29:0] r, input logic [29:0] t, input logic [29:0] b);
    for (int i = 0; i < 30; i++) begin
      check($sformatf("%s brb_w%0d", tag, i), brbselect[i*30 +: 30], eb[i*30 +: 30]);
    end
    check({tag, " left"}, leftioselect, l);
    check({tag, " right"}, rightioselect, r);
    check({tag, " top"}, topioselect, t);
    check({tag, " bottom"}, bottomioselect, b);
  endtask

  // Holds the word until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [29:0] d);
    int n = 0;
    cfg_data  = d;
    cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cfg_ready !== 1'b1) begin
      check("send_ready_timeout", {29'd0, cfg_ready}, 30'd1);
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    exp_brb   = '0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check_flags("in_reset", 5'b00000);
    check_sel("in_reset", exp_brb, 30'h0, 30'h0, 30'h0, 30'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_flags("release", 5'b00000);
    @(posedge clk);
    #1;
    check_flags("release_c1", 5'b10000);
    repeat (4) begin
      @(posedge clk);
      #1;
      check_flags("idle", 5'b10000);
    end

    // Left IO frame then END
    send(30'h29400001);
    check_flags("left_hdr", 5'b11000);
    send(30'h00000001);
    check_flags("left_data", 5'b10000);
    check({"left_val"}, leftioselect, 30'h1);
    send(30'h29400007);
    check_flags("end1", 5'b10101);

    // brb frame with a 3-cycle gap
    send(30'h29400000);
    check_flags("brb_hdr", 5'b11000);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_flags("brb_gap", 5'b11000);
    end
    send(30'h00000020);
    check_flags("brb_data", 5'b10000);
    exp_brb[29:0] = 30'h20;
    check_sel("brb_bit5", exp_brb, 30'h1, 30'h0, 30'h0, 30'h0);

    // Range error at top of brb, END ignored, CLEAR recovers
    send(30'h29401D08);
    check_flags("s29n2", 5'b10010);
    check_sel("s29n2", exp_brb, 30'h1, 30'h0, 30'h0, 30'h0);
    send(30'h29400007);
    check_flags("end_err", 5'b10010);
    send(30'h29400006);
    check_flags("clear", 5'b10000);
    exp_brb = '0;
    check_sel("clear", exp_brb, 30'h0, 30'h0, 30'h0, 30'h0);

    // Other bad headers
    send(30'h00000001);
    check_flags("bad_magic", 5'b10010);
    send(30'h29400006);
    send(30'h29400101);
    check_flags("io_start1", 5'b10010);
    send(30'h29400006);
    send(30'h29400009);
    check_flags("io_n2", 5'b10010);
    send(30'h29400006);
    send(30'h29400005);
    check_flags("tgt5", 5'b10010);
    send(30'h29400006);
    check_flags("clear2", 5'b10000);

    // Two-word brb frame at S=5
    send(30'h29400508);
    check_flags("s5_hdr", 5'b11000);
    send(30'h3FFFFFFF);
    check_flags("s5_w0", 5'b11000);
    send(30'h00000003);
    check_flags("s5_w1", 5'b10000);
    exp_brb[150 +: 30] = 30'h3FFFFFFF;
    exp_brb[180 +: 30] = 30'h00000003;
    check_sel("s5", exp_brb, 30'h0, 30'h0, 30'h0, 30'h0);

    // S=29,N=1 legal, back-to-back with a top frame whose payload looks like END
    send(30'h29401D00);
    check_flags("s29_hdr", 5'b11000);
    send(30'h00012345);
    send(30'h29400003);
    check_flags("top_hdr", 5'b11000);
    send(30'h29400007);
    check_flags("top_data", 5'b10000);
    exp_brb[870 +: 30] = 30'h00012345;
    check_sel("s29_top", exp_brb, 30'h0, 30'h0, 30'h29400007, 30'h0);
    send(30'h29400004);
    send(30'h15555555);
    send(30'h29400007);
    check_flags("end2", 5'b10101);
    check({"bottom_val"}, bottomioselect, 30'h15555555);

    // Reset mid-frame
    send(30'h29400508);
    send(30'h3FFFFFFF);
    check_flags("pre_rst", 5'b11000);
    rst_n = 1'b0;
    #1;
    check_flags("mid_rst", 5'b00000);
    exp_brb = '0;
    check_sel("mid_rst", exp_brb, 30'h0, 30'h0, 30'h0, 30'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(30'h29400002);
    check_flags("post_hdr", 5'b11000);
    send(30'h2AAAAAAA);
    check_flags("post_data", 5'b10000);
    send(30'h29400007);
    check_flags("post_end", 5'b10101);
    check_sel("post", exp_brb, 30'h0, 30'h2AAAAAAA, 30'h0, 30'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fabric_config_loader.md
# fabric_config_loader

Loads the fabric configuration registers from a word-wide framed stream: the routing-block select vector and the four IO-block select vectors. Sits between the external configuration port and the fabric, driving `brbselect` and the left/right/top/bottom IO select buses. It also gates fabric operation until a complete, error-free configuration has been committed.

## Interface
- `WORD`, 30: config word width. Every select vector is a whole number of words.
- `BRB_BITS`, 900: routing-block select width, giving `BRB_WORDS` = 30.
- `IO_BITS`, 30: width of each IO-side select, giving 1 word.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_data`  in  WORD  header or payload word.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  loader accepts a word. A word transfers when `cfg_valid` and `cfg_ready` are both high on a rising edge.
- `brbselect`  out  BRB_BITS  routing-block select.
- `leftioselect`, `rightioselect`, `topioselect`, `bottomioselect`  out  IO_BITS each  IO-block selects.
- `cfg_busy`  out  1  a payload is in progress (state LOAD).
- `cfg_done`  out  1  a configuration has been committed.
- `cfg_error`  out  1  sticky protocol error.
- `fabric_en`  out  1  fabric may run.

## Operation
- **Header word fields**
  - [29:22] magic, must equal 8'hA5.
  - [21:14] reserved, ignored.
  - [13:8] start word index S.
  - [7:3] count-1, so word count N ranges 1..32.
  - [2:0] target: 0 brb, 1 left, 2 right, 3 top, 4 bottom, 5 invalid, 6 CLEAR, 7 END.
- **FSM states**
  - IDLE: waiting for a header.
  - LOAD: accepting payload words.
- **IDLE, header accepted**
  - Bad magic, target 5, or range fail sets `cfg_error` and the FSM stays in IDLE.
  - Range fail for brb: S+N > 30. Range fail for IO targets: S≠0 or N≠1.
  - Valid target 0..4: capture the target, load the word pointer with S and the remaining count with N, clear `fabric_en` and `cfg_done`, go to LOAD.
  - CLEAR: zero all select vectors and clear `cfg_done`, `fabric_en` and `cfg_error`. Stay in IDLE.
  - END: if `cfg_error`=0, set `cfg_done` and `fabric_en`. If `cfg_error`=1, no effect. Stay in IDLE.
- **LOAD, payload word accepted**
  - brb target: write bits [WORD*p+WORD-1 : WORD*p] of `brbselect`, where p is the word pointer.
  - IO target: overwrite the whole selected IO vector.
  - Increment the pointer and decrement the remaining count. At the last word, return to IDLE.
  - Payload contents are never decoded; a magic-looking word is data.
- **Selects and errors**
  - Selects not addressed by a frame keep their values.
  - `cfg_error` is cleared only by CLEAR or reset.
- **Handshake**
  - `cfg_ready` is 1 in IDLE and LOAD.
  - `cfg_ready` is 0 during reset and for the first cycle after `rst_n` deasserts.
  - `cfg_valid` low holds all state; there is no timeout.

## Timing
- Reset values: all select vectors 0, `cfg_ready` 0, `cfg_busy` 0, `cfg_done` 0, `cfg_error` 0, `fabric_en` 0, state IDLE.
- Header accepted at edge t: `cfg_busy`=1 and `fabric_en`=0 from t+1.
- Payload word accepted at t: the written select bits are visible at t+1.
- Last payload word accepted at t: `cfg_busy`=0 at t+1, and the next word is taken as a header.
- END accepted at t: `cfg_done`=1 and `fabric_en`=1 at t+1.
- Bad header at t: `cfg_error`=1 at t+1.
- A frame covering word 29 of the brb vector is legal (S=29, N=1). S=29, N=2 is an error.
- Back-to-back frames with no idle cycle are supported.
- `rst_n` low mid-LOAD: immediate return to the reset values, partial frame discarded.

## Test plan
- Reset, then idle for 5 cycles -> all outputs 0 except `cfg_ready`=1 from the 2nd cycle after release.
- Send 0x29400001, then 0x00000001, then 0x29400007 -> `leftioselect`=30'h1; `cfg_done`=1 and `fabric_en`=1 one cycle after END.
- Send 0x29400000, then 0x00000020 with `cfg_valid` low for 3 cycles between the two words -> `brbselect`[5]=1 only, and `cfg_busy` stays high through the gap.
- Send 0x29401D08 (S=29, N=2) -> `cfg_error`=1 and selects unchanged. Then END -> `cfg_done` stays 0. Then 0x29400006 -> `cfg_error`=0 and all selects 0.
- Send header 0x29400508 (S=5, N=2), then words 0x3FFFFFFF and 0x00000003 -> `brbselect`[179:150] all ones, `brbselect`[181:180]=2'b11, all other bits 0.
- Accept header plus 1 of 2 payload words, then pulse `rst_n` low -> all outputs 0 immediately; the next header is decoded normally.
